// File: rtl/game_io_ctrl.sv
// ---------------------------------------------------------------------------
// game_io_ctrl
//   Memory-mapped game I/O block for a small soft processor. It provides:
//     - NUM_CH push buttons: synchronized, debounced, reduced to a single
//       press-event register that is cleared when it is read.
//     - NUM_CH LEDs that can be switched steady on, switched off, or flashed
//       for FLASH_CYC cycles.
//     - A free-running 32-bit Galois LFSR as a random-number source.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   wren          in   processor store strobe
//   rden          in   processor load strobe
//   address_dmem  in   [11:0] word address
//   data          in   [31:0] store data
//   buttons       in   [NUM_CH-1:0] raw asynchronous buttons, active high
//   q_io          out  [31:0] read data, combinational from address_dmem
//   hit           out  address_dmem selects one of the three registers
//   leds          out  [NUM_CH-1:0] LED drives, active high
//
// Register map
//   ADDR_RAND  R: current LFSR state     W: reseed (0 reseeds to 32'hACE10001)
//   ADDR_LED   R: LED states             W: [7:0] chan, [8] on, [9] timed
//   ADDR_BTN   R: {overflow[9], valid[8], chan[7:0]}, cleared by the read
// ---------------------------------------------------------------------------
module game_io_ctrl #(
    parameter int          NUM_CH       = 4,
    parameter int          DEBOUNCE_CYC = 1000000,
    parameter int          FLASH_CYC    = 25000000,
    parameter logic [11:0] ADDR_RAND    = 12'd5,
    parameter logic [11:0] ADDR_LED     = 12'd6,
    parameter logic [11:0] ADDR_BTN     = 12'd7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wren,
    input  logic              rden,
    input  logic [11:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic [NUM_CH-1:0] buttons,
    output logic [31:0]       q_io,
    output logic              hit,
    output logic [NUM_CH-1:0] leds
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int FL_W = $clog2(FLASH_CYC + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [FL_W-1:0] FL_LAST   = FL_W'(FLASH_CYC - 1);
    localparam logic [31:0]     LFSR_SEED = 32'hACE10001;
    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0]     LFSR_TAPS = 32'h80200003;

    // -----------------------------------------------------------------------
    // Button synchronizers and debouncers
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [NUM_CH-1:0] r_deb;
    logic [DB_W-1:0]   r_db_cnt [NUM_CH];

    logic [NUM_CH-1:0] w_db_done;
    logic [NUM_CH-1:0] w_press;
    logic [7:0]        w_low_chan;
    logic              w_multi;

    // A channel flips on the cycle its mismatch run reaches DEBOUNCE_CYC.
    // NOTE: every signal assigned in always_comb gets a default before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_db_done = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_db_done[i] = (r_sync2[i] != r_deb[i]) && (r_db_cnt[i] == DB_LAST);
        end
    end

    // A completing change towards 1 is a press; towards 0 is silently accepted.
    assign w_press = w_db_done & r_sync2;

    // Lowest pressed index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_low_chan = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_press[i]) begin
                w_low_chan = 8'(i);
            end
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign w_multi = (w_press & (w_press - NUM_CH'(1))) != '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            // NOTE: the counter array is cleared element by element because a
            // reset must abort any debounce in flight; plain storage arrays
            // without that requirement would be left unreset.
            for (int i = 0; i < NUM_CH; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_done[i]) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Press-event register
    // -----------------------------------------------------------------------
    logic       r_ev_valid;
    logic       r_ev_ovf;
    logic [7:0] r_ev_chan;
    logic       w_rd_btn;

    assign w_rd_btn = rden && (address_dmem == ADDR_BTN);

    // A clearing read empties the register first, so a press in the same
    // cycle lands in a fresh register while the read returns the old value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ev_valid <= 1'b0;
            r_ev_ovf   <= 1'b0;
            r_ev_chan  <= '0;
        end else if (w_rd_btn) begin
            r_ev_valid <= |w_press;
            r_ev_ovf   <= w_multi;
            r_ev_chan  <= (|w_press) ? w_low_chan : 8'd0;
        end else if (|w_press) begin
            if (!r_ev_valid) begin
                r_ev_valid <= 1'b1;
                r_ev_chan  <= w_low_chan;
                r_ev_ovf   <= w_multi;
            end else begin
                r_ev_ovf   <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // LED drivers with per-channel flash timers
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] r_led;
    logic [NUM_CH-1:0] r_timed;
    logic [FL_W-1:0]   r_timer [NUM_CH];
    logic              w_led_wr;

    assign w_led_wr = wren && (address_dmem == ADDR_LED) && (data[7:0] < 8'(NUM_CH));

    // Timed mode loads FLASH_CYC-1 and turns off on the edge after the timer
    // has reached 0, giving exactly FLASH_CYC lit cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_led   <= '0;
            r_timed <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_led_wr && (data[7:0] == 8'(i))) begin
                    r_led[i]   <= data[8];
                    r_timed[i] <= data[8] & data[9];
                    r_timer[i] <= (data[8] && data[9]) ? FL_LAST : '0;
                end else if (r_led[i] && r_timed[i]) begin
                    if (r_timer[i] == '0) begin
                        r_led[i]   <= 1'b0;
                        r_timed[i] <= 1'b0;
                    end else begin
                        r_timer[i] <= r_timer[i] - FL_W'(1);
                    end
                end
            end
        end
    end

    assign leds = r_led;

    // -----------------------------------------------------------------------
    // Random-number LFSR
    // -----------------------------------------------------------------------
    logic [31:0] r_lfsr;
    logic [31:0] w_lfsr_next;
    logic        w_rand_wr;

    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
    assign w_rand_wr   = wren && (address_dmem == ADDR_RAND);

    // A zero store is replaced by the seed so the LFSR never locks up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_rand_wr) begin
            r_lfsr <= (data == 32'h0) ? LFSR_SEED : data;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and address decode (independent of rden)
    // -----------------------------------------------------------------------
    always_comb begin
        q_io = '0;
        hit  = 1'b0;
        if (address_dmem == ADDR_RAND) begin
            q_io = r_lfsr;
            hit  = 1'b1;
        end else if (address_dmem == ADDR_LED) begin
            q_io[NUM_CH-1:0] = r_led;
            hit              = 1'b1;
        end else if (address_dmem == ADDR_BTN) begin
            q_io[9:0] = {r_ev_ovf, r_ev_valid, r_ev_chan};
            hit       = 1'b1;
        end
    end

endmodule

// File: tb/tb_game_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_io_ctrl
//   Scoreboard bench for game_io_ctrl (NUM_CH=4, DEBOUNCE_CYC=4, FLASH_CYC=8).
//   A reference model tracks buttons, events, LED on-time and the LFSR from
//   the behavioural rules; reads push their expected data into a queue and a
//   monitor pops and compares whenever the DUT is read. LEDs and hit are
//   compared against the model every cycle.
// ---------------------------------------------------------------------------
module tb_game_io_ctrl;

    localparam int          NUM_CH = 4;
    localparam int          DEB    = 4;
    localparam int          FLASH  = 8;
    localparam logic [11:0] A_RAND = 12'd5;
    localparam logic [11:0] A_LED  = 12'd6;
    localparam logic [11:0] A_BTN  = 12'd7;
    localparam logic [11:0] A_NONE = 12'd9;
    localparam logic [31:0] SEED   = 32'hACE10001;

    logic              clock        = 1'b0;
    logic              reset        = 1'b0;
    logic              wren         = 1'b0;
    logic              rden         = 1'b0;
    logic [11:0]       address_dmem = '0;
    logic [31:0]       data         = '0;
    logic [NUM_CH-1:0] buttons      = '0;
    logic [31:0]       q_io;
    logic              hit;
    logic [NUM_CH-1:0] leds;

    game_io_ctrl #(
        .NUM_CH       (NUM_CH),
        .DEBOUNCE_CYC (DEB),
        .FLASH_CYC    (FLASH),
        .ADDR_RAND    (A_RAND),
        .ADDR_LED     (A_LED),
        .ADDR_BTN     (A_BTN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .rden         (rden),
        .address_dmem (address_dmem),
        .data         (data),
        .buttons      (buttons),
        .q_io         (q_io),
        .hit          (hit),
        .leds         (leds)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    bit          m_s1  [NUM_CH];
    bit          m_s2  [NUM_CH];
    bit          m_lvl [NUM_CH];
    int          m_run [NUM_CH];   // length of the current mismatch run
    int          m_rem [NUM_CH];   // lit cycles left: 0 off, -1 steady on
    bit          m_valid;
    bit          m_ovf;
    int          m_chan;
    logic [31:0] m_lfsr;

    // Multiply by x modulo x^32+x^22+x^2+x+1, bit-reversed representation.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [NUM_CH-1:0] model_leds();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i] = (m_rem[i] != 0);
        return v;
    endfunction

    function automatic logic [31:0] model_q(input logic [11:0] a);
        if (a == A_RAND) return m_lfsr;
        if (a == A_LED)  return 32'(model_leds());
        if (a == A_BTN)  return (32'(m_ovf) << 9) | (32'(m_valid) << 8) | 32'(m_chan);
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_rem[i] = 0;
        end
        m_valid = 0; m_ovf = 0; m_chan = 0; m_lfsr = SEED;
    endtask

    task automatic model_step();
        int first;
        int npress;
        int ch;
        first  = -1;
        npress = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) begin
                        npress++;
                        if (first < 0) first = i;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            m_s2[i] = m_s1[i];
            m_s1[i] = buttons[i];
        end
        if (rden && address_dmem == A_BTN) begin
            m_valid = 0; m_ovf = 0; m_chan = 0;
        end
        if (npress > 0) begin
            if (!m_valid) begin
                m_valid = 1; m_chan = first; m_ovf = (npress > 1);
            end else begin
                m_ovf = 1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) if (m_rem[i] > 0) m_rem[i]--;
        if (wren && address_dmem == A_LED && int'(data[7:0]) < NUM_CH) begin
            ch = int'(data[7:0]);
            if (!data[8])     m_rem[ch] = 0;
            else if (data[9]) m_rem[ch] = FLASH;
            else              m_rem[ch] = -1;
        end
        if (wren && address_dmem == A_RAND) m_lfsr = (data == 0) ? SEED : data;
        else                                m_lfsr = lfsr_step(m_lfsr);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard and monitor
    // -----------------------------------------------------------------------
    typedef struct {
        logic [11:0] addr;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];

    initial begin
        forever begin
            @(negedge clock);
            #3;
            check("leds", 32'(leds), 32'(model_leds()));
            check("hit", 32'(hit),
                  32'(address_dmem == A_RAND || address_dmem == A_LED || address_dmem == A_BTN));
            if (rden) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL read: no expected value queued at t=%0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("q_io@%0d", e.addr), q_io, e.value);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic op(input bit we, input bit re, input logic [11:0] a, input logic [31:0] d);
        @(negedge clock);
        wren = we; rden = re; address_dmem = a; data = d;
        if (re) exp_q.push_back('{addr: a, value: model_q(a)});
    endtask

    task automatic read_expect(input logic [11:0] a, input logic [31:0] v);
        @(negedge clock);
        wren = 0; rden = 1; address_dmem = a; data = 0;
        exp_q.push_back('{addr: a, value: v});
    endtask

    task automatic idle(input int n);
        repeat (n) op(0, 0, 12'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        logic [11:0] raddr;

        // Reset state
        address_dmem = A_RAND;
        repeat (2) @(negedge clock);
        #1;
        check("reset_rand", q_io, SEED);
        check("reset_leds", 32'(leds), 32'h0);
        address_dmem = A_BTN;
        #1;
        check("reset_btn", q_io, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // LFSR: first read after reset is one step past the seed; zero reseeds
        read_expect(A_RAND, lfsr_step(SEED));
        op(1, 0, A_RAND, 32'h0);
        read_expect(A_RAND, SEED);
        op(1, 0, A_RAND, 32'h1234_5678);
        op(0, 1, A_RAND, 32'h0);

        // Press on channel 2, then clearing read
        idle(1);
        buttons = 4'b0100;
        idle(10);
        buttons = 4'b0000;
        read_expect(A_BTN, 32'h0000_0102);
        read_expect(A_BTN, 32'h0000_0000);
        idle(10);

        // 3-cycle glitch on channel 1 is rejected
        buttons = 4'b0010;
        idle(3);
        buttons = 4'b0000;
        idle(10);
        read_expect(A_BTN, 32'h0000_0000);

        // Simultaneous presses on channels 0 and 3
        buttons = 4'b1001;
        idle(10);
        buttons = 4'b0000;
        read_expect(A_BTN, 32'h0000_0300);
        idle(10);

        // Press while valid sets overflow and keeps the channel
        buttons = 4'b0010;
        idle(10);
        buttons = 4'b0000;
        idle(8);
        buttons = 4'b1000;
        idle(10);
        buttons = 4'b0000;
        read_expect(A_BTN, 32'h0000_0301);
        idle(10);

        // Timed flash of exactly FLASH cycles
        op(1, 0, A_LED, 32'h0000_0301);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            #3;
            if (leds[1]) cnt++;
        end
        check("flash_len", 32'(cnt), 32'(FLASH));

        // Steady on, then an out-of-range channel write is ignored
        op(1, 0, A_LED, 32'h0000_0100);
        op(1, 0, A_LED, 32'h0000_0105);
        idle(2);
        #3;
        check("led_ignore", 32'(leds), 32'h1);
        op(1, 0, A_LED, 32'h0000_0000);
        op(1, 0, A_BTN, 32'hFFFF_FFFF);
        idle(2);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 5) == 0) buttons[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
            case ($urandom_range(0, 9))
                0, 1, 2: op(1, 0, A_LED, {22'h0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 5))});
                3:       op(1, 0, A_RAND, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom());
                4:       op(1, 0, A_BTN, $urandom());
                5, 6, 7, 8: begin
                    case ($urandom_range(0, 3))
                        0:       raddr = A_RAND;
                        1:       raddr = A_LED;
                        2:       raddr = A_BTN;
                        default: raddr = A_NONE;
                    endcase
                    op(0, 1, raddr, 32'h0);
                end
                default: idle(1);
            endcase
        end
        buttons = '0;
        op(1, 0, A_LED, 32'h0000_0000);
        op(1, 0, A_LED, 32'h0000_0001);
        op(1, 0, A_LED, 32'h0000_0002);
        op(1, 0, A_LED, 32'h0000_0003);
        idle(10);
        op(0, 1, A_BTN, 32'h0);
        idle(2);

        // Reset during a timed flash and a debounce in progress
        op(1, 0, A_LED, 32'h0000_0302);
        buttons = 4'b0001;
        idle(4);
        address_dmem = A_RAND;
        #2;
        reset = 1'b0;
        #1;
        check("async_leds", 32'(leds), 32'h0);
        check("async_rand", q_io, SEED);
        repeat (3) @(negedge clock);
        buttons = 4'b0000;
        @(negedge clock);
        reset = 1'b1;
        idle(12);
        #3;
        check("post_reset_leds", 32'(leds), 32'h0);
        read_expect(A_BTN, 32'h0000_0000);
        idle(2);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
